// File: rtl/pca_mmio_pkg.sv
// Shared definitions for the PCA MMIO register bank: register offsets, field
// positions, response record and the offset decoder.
package pca_mmio_pkg;

  localparam logic [7:0] OFF_ID         = 8'h00;
  localparam logic [7:0] OFF_CTRL       = 8'h04;
  localparam logic [7:0] OFF_STATUS     = 8'h08;
  localparam logic [7:0] OFF_SCRATCH    = 8'h0C;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h10;
  localparam logic [7:0] OFF_IRQ_ENABLE = 8'h14;
  localparam logic [7:0] OFF_CMD_DATA   = 8'h18;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_SRST_BIT    = 1;
  localparam int unsigned IRQ_OVF_BIT      = 0;
  localparam int unsigned IRQ_DONE_BIT     = 1;
  localparam int unsigned IRQ_W            = 2;
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_FILL_LSB  = 8;
  localparam int unsigned STATUS_FILL_W    = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mmio_rsp_t;

  typedef enum logic [2:0] {
    REG_ID,
    REG_CTRL,
    REG_STATUS,
    REG_SCRATCH,
    REG_IRQ_STATUS,
    REG_IRQ_ENABLE,
    REG_CMD_DATA,
    REG_NONE
  } reg_sel_e;

  // Misaligned offsets never match an entry, so they fall out as REG_NONE.
  function automatic reg_sel_e decode_reg(input logic [7:0] off);
    case (off)
      OFF_ID:         return REG_ID;
      OFF_CTRL:       return REG_CTRL;
      OFF_STATUS:     return REG_STATUS;
      OFF_SCRATCH:    return REG_SCRATCH;
      OFF_IRQ_STATUS: return REG_IRQ_STATUS;
      OFF_IRQ_ENABLE: return REG_IRQ_ENABLE;
      OFF_CMD_DATA:   return REG_CMD_DATA;
      default:        return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pca_mmio_regbank_fifo.sv
// Synchronous command FIFO with flush; pushes while full and pops while empty
// are ignored, flush overrides both.
module pca_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    push_en  = push & ~full & ~flush;
    pop_en   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pca_mmio_regbank.sv
// MMIO register bank behind the AXI-Lite-to-PCA bridge: one outstanding
// request, registered response, CSRs, IRQ logic and the command FIFO.
module pca_mmio_regbank
  import pca_mmio_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned CMD_DEPTH = 16,
  parameter logic [31:0] ID_VALUE  = 32'h0CA0_0100
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              mmio_req_valid,
  output logic              mmio_req_ready,
  input  logic              mmio_req_write,
  input  logic [ADDR_W-1:0] mmio_req_addr,
  input  logic [31:0]       mmio_req_wdata,
  input  logic [3:0]        mmio_req_wstrb,
  output logic              mmio_rsp_valid,
  input  logic              mmio_rsp_ready,
  output logic [31:0]       mmio_rsp_rdata,
  output logic              mmio_rsp_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [31:0]       cmd_data,
  input  logic              done_i,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(CMD_DEPTH) + 1;

  logic             rsp_valid_q, rsp_valid_d;
  mmio_rsp_t        rsp_q, rsp_d;
  logic             ctrl_en_q, ctrl_en_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [IRQ_W-1:0] irq_status_q, irq_status_d;
  logic [IRQ_W-1:0] irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic             req_accept, soft_rst, cmd_push, cmd_pop, ovf;
  logic [IRQ_W-1:0] w1c, irq_set;
  reg_sel_e         sel;
  logic [31:0]      status_word;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign mmio_req_ready = ~rsp_valid_q;
  assign mmio_rsp_valid = rsp_valid_q;
  assign mmio_rsp_rdata = rsp_q.rdata;
  assign mmio_rsp_err   = rsp_q.err;
  assign irq            = irq_q;
  assign cmd_valid      = ~fifo_empty & ctrl_en_q;
  assign cmd_pop        = cmd_valid & cmd_ready;
  assign req_accept     = mmio_req_valid & mmio_req_ready;

  always_comb begin
    sel         = ((mmio_req_addr >> 8) == '0) ? decode_reg(mmio_req_addr[7:0]) : REG_NONE;
    status_word = '0;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_FILL_LSB +: STATUS_FILL_W] = STATUS_FILL_W'(fifo_count);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    ctrl_en_d   = ctrl_en_q;
    scratch_d   = scratch_q;
    irq_en_d    = irq_en_q;
    soft_rst    = 1'b0;
    w1c         = '0;
    cmd_push    = 1'b0;
    if (rsp_valid_q && mmio_rsp_ready) rsp_valid_d = 1'b0;
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      rsp_d       = '0;
      case (sel)
        REG_ID: begin
          if (mmio_req_write) rsp_d.err   = 1'b1;
          else                rsp_d.rdata = ID_VALUE;
        end
        REG_CTRL: begin
          if (!mmio_req_write) rsp_d.rdata[CTRL_EN_BIT] = ctrl_en_q;
          else if (mmio_req_wstrb[0]) begin
            ctrl_en_d = mmio_req_wdata[CTRL_EN_BIT];
            soft_rst  = mmio_req_wdata[CTRL_SRST_BIT];
          end
        end
        REG_STATUS: begin
          if (mmio_req_write) rsp_d.err   = 1'b1;
          else                rsp_d.rdata = status_word;
        end
        REG_SCRATCH: begin
          if (!mmio_req_write) rsp_d.rdata = scratch_q;
          else begin
            for (int unsigned b = 0; b < 4; b++)
              if (mmio_req_wstrb[b]) scratch_d[8*b +: 8] = mmio_req_wdata[8*b +: 8];
          end
        end
        REG_IRQ_STATUS: begin
          if (!mmio_req_write)        rsp_d.rdata[IRQ_W-1:0] = irq_status_q;
          else if (mmio_req_wstrb[0]) w1c = mmio_req_wdata[IRQ_W-1:0];
        end
        REG_IRQ_ENABLE: begin
          if (!mmio_req_write)        rsp_d.rdata[IRQ_W-1:0] = irq_en_q;
          else if (mmio_req_wstrb[0]) irq_en_d = mmio_req_wdata[IRQ_W-1:0];
        end
        REG_CMD_DATA: begin
          if (mmio_req_write) begin
            if (mmio_req_wstrb == 4'hF) cmd_push = 1'b1;
            else                        rsp_d.err = 1'b1;
          end
        end
        default: rsp_d.err = 1'b1;
      endcase
    end
  end

  // Set sources are OR-ed in after clears, so a same-cycle set beats W1C or soft reset.
  always_comb begin
    ovf                   = cmd_push & fifo_full;
    irq_set               = '0;
    irq_set[IRQ_OVF_BIT]  = ovf;
    irq_set[IRQ_DONE_BIT] = done_i;
    irq_status_d = (soft_rst ? '0 : (irq_status_q & ~w1c)) | irq_set;
    irq_d        = |(irq_status_q & irq_en_q);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rsp_valid_q  <= 1'b0;
      rsp_q        <= '0;
      ctrl_en_q    <= 1'b0;
      scratch_q    <= '0;
      irq_status_q <= '0;
      irq_en_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_q        <= rsp_d;
      ctrl_en_q    <= ctrl_en_d;
      scratch_q    <= scratch_d;
      irq_status_q <= irq_status_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
    end
  end

  pca_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     (32)
  ) u_cmd_fifo (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .flush (soft_rst),
    .wdata (mmio_req_wdata),
    .rdata (cmd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_pca_mmio_regbank.sv
// Bench for pca_mmio_regbank: table-driven register accesses through a response
// scoreboard, plus FIFO overflow/drain, IRQ race, soft reset and stall sequences.
module tb_pca_mmio_regbank;
  import pca_mmio_pkg::*;

  localparam logic [31:0] ID = 32'h0CA0_0100;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [31:0] cmd_data;
  logic        done_i = 1'b0, irq;

  int n_cmp = 0;
  int n_fail = 0;

  mmio_rsp_t   exp_q[$];
  string       exp_name_q[$];
  logic [31:0] cmd_exp_q[$];

  always #5 clk = ~clk;

  pca_mmio_regbank #(
    .ADDR_W    (12),
    .CMD_DEPTH (16),
    .ID_VALUE  (ID)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_areset   (areset),
    .mmio_req_valid (req_valid),
    .mmio_req_ready (req_ready),
    .mmio_req_write (req_write),
    .mmio_req_addr  (req_addr),
    .mmio_req_wdata (req_wdata),
    .mmio_req_wstrb (req_wstrb),
    .mmio_rsp_valid (rsp_valid),
    .mmio_rsp_ready (rsp_ready),
    .mmio_rsp_rdata (rsp_rdata),
    .mmio_rsp_err   (rsp_err),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .done_i         (done_i),
    .irq            (irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Response scoreboard: compare at the negedge before the handshake edge.
  always @(negedge clk) begin
    if (!areset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        mmio_rsp_t e;
        string     nm;
        e  = exp_q.pop_front();
        nm = exp_name_q.pop_front();
        chk({nm, "_rdata"}, rsp_rdata, e.rdata);
        chk({nm, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (!areset && cmd_valid && cmd_ready) begin
      if (cmd_exp_q.size() == 0) chk("cmd_unexpected", cmd_data, 32'hFFFF_FFFF);
      else chk("cmd_pop", cmd_data, cmd_exp_q.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic xact(input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] er, input logic ee,
                      input string nm, input logic pulse_done = 1'b0);
    mmio_rsp_t e;
    for (int k = 0; k < 20 && !req_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    done_i = pulse_done;
    @(posedge clk); #1;
    req_valid = 1'b0; done_i = 1'b0;
    e.rdata = er; e.err = ee;
    exp_q.push_back(e);
    exp_name_q.push_back(nm);
    chk({nm, "_latency"}, {31'b0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b0, 12'h000, 32'h0,         4'h0,    ID,            1'b0};
    vecs[1]  = '{1'b0, 12'h01C, 32'h0,         4'h0,    32'h0,         1'b1};
    vecs[2]  = '{1'b1, 12'h00C, 32'hDEAD_BEEF, 4'b0101, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 12'h00C, 32'h0,         4'h0,    32'h00AD_00EF, 1'b0};
    vecs[4]  = '{1'b0, 12'h00E, 32'h0,         4'h0,    32'h0,         1'b1};
    vecs[5]  = '{1'b1, 12'h000, 32'h1234_5678, 4'hF,    32'h0,         1'b1};
    vecs[6]  = '{1'b1, 12'h008, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1};
    vecs[7]  = '{1'b0, 12'h008, 32'h0,         4'h0,    32'h1,         1'b0};
    vecs[8]  = '{1'b0, 12'h018, 32'h0,         4'h0,    32'h0,         1'b0};
    vecs[9]  = '{1'b1, 12'h018, 32'hAAAA_0001, 4'h7,    32'h0,         1'b1};
    vecs[10] = '{1'b0, 12'h008, 32'h0,         4'h0,    32'h1,         1'b0};
    vecs[11] = '{1'b0, 12'h004, 32'h0,         4'h0,    32'h0,         1'b0};
    vecs[12] = '{1'b1, 12'h014, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b0};
    vecs[13] = '{1'b0, 12'h014, 32'h0,         4'h0,    32'h3,         1'b0};
    vecs[14] = '{1'b1, 12'h014, 32'h0,         4'hF,    32'h0,         1'b0};
    vecs[15] = '{1'b0, 12'h010, 32'h0,         4'h0,    32'h0,         1'b0};
    vecs[16] = '{1'b0, 12'h104, 32'h0,         4'h0,    32'h0,         1'b1};

    repeat (3) @(posedge clk);
    #1 areset = 1'b0;

    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);

    for (int i = 0; i < 17; i++)
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
           vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));

    // Overflow with the engine stalled (enable=0), then drain.
    for (int i = 1; i <= 16; i++) begin
      xact(1'b1, 12'h018, i, 4'hF, 32'h0, 1'b0, "push");
      cmd_exp_q.push_back(i);
    end
    xact(1'b0, 12'h008, 32'h0, 4'h0, 32'h0000_1002, 1'b0, "status_full");
    xact(1'b1, 12'h018, 32'd17, 4'hF, 32'h0, 1'b0, "push_ovf");
    xact(1'b0, 12'h010, 32'h0, 4'h0, 32'h1, 1'b0, "irq_ovf_set");
    chk("irq_masked", {31'b0, irq}, 32'd0);
    xact(1'b1, 12'h014, 32'h1, 4'hF, 32'h0, 1'b0, "irq_en_ovf");
    chk("irq_ovf", {31'b0, irq}, 32'd1);
    xact(1'b1, 12'h010, 32'h1, 4'hF, 32'h0, 1'b0, "w1c_ovf");
    chk("irq_ovf_clr", {31'b0, irq}, 32'd0);
    cmd_ready = 1'b1;
    xact(1'b1, 12'h004, 32'h1, 4'hF, 32'h0, 1'b0, "ctrl_en");
    for (int k = 0; k < 50 && cmd_exp_q.size() != 0; k++) @(posedge clk);
    chk("drain_done", cmd_exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("cmd_17_absent", {31'b0, cmd_valid}, 32'd0);
    cmd_ready = 1'b0;

    // done_i set races a W1C of the same bit.
    xact(1'b1, 12'h014, 32'h2, 4'hF, 32'h0, 1'b0, "irq_en_done");
    done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    chk("irq_done_lag", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_done", {31'b0, irq}, 32'd1);
    xact(1'b1, 12'h010, 32'h2, 4'hF, 32'h0, 1'b0, "w1c_race", 1'b1);
    xact(1'b0, 12'h010, 32'h0, 4'h0, 32'h2, 1'b0, "irq_set_wins");
    xact(1'b1, 12'h010, 32'h2, 4'hF, 32'h0, 1'b0, "w1c_done");
    xact(1'b0, 12'h010, 32'h0, 4'h0, 32'h0, 1'b0, "irq_done_clr");

    // Soft reset with 5 commands queued and a pending done flag.
    xact(1'b1, 12'h004, 32'h0, 4'hF, 32'h0, 1'b0, "ctrl_dis");
    for (int i = 0; i < 5; i++) xact(1'b1, 12'h018, 32'h100 + i, 4'hF, 32'h0, 1'b0, "push5");
    done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    xact(1'b0, 12'h008, 32'h0, 4'h0, 32'h0000_0500, 1'b0, "status_5");
    xact(1'b1, 12'h004, 32'h3, 4'hF, 32'h0, 1'b0, "soft_rst");
    xact(1'b0, 12'h008, 32'h0, 4'h0, 32'h1, 1'b0, "status_flushed");
    xact(1'b0, 12'h010, 32'h0, 4'h0, 32'h0, 1'b0, "irq_flushed");
    xact(1'b0, 12'h004, 32'h0, 4'h0, 32'h1, 1'b0, "ctrl_kept");
    xact(1'b0, 12'h014, 32'h0, 4'h0, 32'h2, 1'b0, "irq_en_kept");
    xact(1'b0, 12'h00C, 32'h0, 4'h0, 32'h00AD_00EF, 1'b0, "scratch_kept");

    // Stalled response, then hard reset while it is pending.
    xact(1'b1, 12'h018, 32'h55, 4'hF, 32'h0, 1'b0, "push_hold");
    chk("cmd_valid_hold", {31'b0, cmd_valid}, 32'd1);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h00C; req_wstrb = 4'h0;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h00AD_00EF);
      chk("hold_rsp_err", {31'b0, rsp_err}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    areset = 1'b1;
    @(posedge clk); #1 areset = 1'b0;
    chk("rst_drop_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rst_drop_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_drop_cmd", {31'b0, cmd_valid}, 32'd0);
    rsp_ready = 1'b1;
    xact(1'b0, 12'h008, 32'h0, 4'h0, 32'h1, 1'b0, "status_after_rst");
    xact(1'b0, 12'h004, 32'h0, 4'h0, 32'h0, 1'b0, "ctrl_after_rst");

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule
